// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen - pattern generator for the Genius game datapath.
//
// A free-running 16-bit Galois LFSR supplies the entropy. The game FSM asks for
// a new sequence with new_seq. The block then fills DEPTH = 2^ADDR_W memory
// words, one per cycle, with one-hot colours. The LED and button comparators
// read the sequence back through a registered, addressed port.
//
// Parameters
//   N_COLORS  : number of colours and one-hot width (power of two, 2..8)
//   ADDR_W    : address width, sequence depth is 2^ADDR_W
//   SEED      : LFSR value loaded by reset (must be non-zero)
//   NO_REPEAT : 1 = no element equals its predecessor
//
// Ports
//   clock   in   single clock, rising edge
//   reset   in   synchronous active-high reset
//   new_seq in   request a new sequence (pulse or level)
//   address in   read index
//   saida   out  registered one-hot colour at address (0 while masked)
//   busy    out  fill in progress
//   done    out  one-cycle pulse when the fill completes
//   valid   out  memory holds a complete sequence
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int          N_COLORS  = 4,
  parameter int          ADDR_W    = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter bit          NO_REPEAT = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                new_seq,
  input  logic [ADDR_W-1:0]   address,
  output logic [N_COLORS-1:0] saida,
  output logic                busy,
  output logic                done,
  output logic                valid
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam int          CIDX_W   = $clog2(N_COLORS);
  localparam logic [15:0] TAP_MASK = 16'hB400;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [15:0]         lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CIDX_W-1:0]   prev_c_q, prev_c_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [N_COLORS-1:0] saida_q, saida_d;

  // Sequence storage, one one-hot word per element.
  logic [N_COLORS-1:0] mem [DEPTH];

  logic                wr_en;
  logic                last_elem;
  logic [CIDX_W-1:0]   raw_c;
  logic [CIDX_W-1:0]   wr_c;
  logic [N_COLORS-1:0] wr_onehot;

  // ---------------------------------------------------------------------------
  // LFSR. It shifts every non-reset cycle, whatever the state, so the moment
  // the player starts a game decides which part of the stream is used.
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAP_MASK : 16'h0000);
  end

  // ---------------------------------------------------------------------------
  // Colour selection. The element index comes from the LFSR value held during
  // the write cycle. With NO_REPEAT, a repeat of the previous colour is bumped
  // to the next colour. N_COLORS is a power of two, so CIDX_W-bit wraparound
  // gives the modulo for free. Element 0 has no predecessor and is never bumped.
  // ---------------------------------------------------------------------------
  assign raw_c     = lfsr_q[CIDX_W-1:0];
  assign last_elem = (idx_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    wr_c = raw_c;
    if (NO_REPEAT && (idx_q != '0) && (raw_c == prev_c_q)) begin
      wr_c = raw_c + CIDX_W'(1);
    end
  end

  // Index to one-hot decoder.
  generate
    for (genvar gi = 0; gi < N_COLORS; gi++) begin : g_onehot
      assign wr_onehot[gi] = (wr_c == CIDX_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // All registered outputs share this block so that reset clears them together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      prev_c_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      saida_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      prev_c_q <= prev_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      saida_q  <= saida_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. While in FILL, new_seq is ignored. A held new_seq
  // is seen again on the first IDLE cycle, which gives busy a one-cycle gap.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (new_seq)   state_d = S_FILL;
      S_FILL: if (last_elem) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls (next values of the output registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;
    prev_c_d = prev_c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_seq) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      S_FILL: begin
        wr_en    = 1'b1;
        prev_c_d = wr_c;
        idx_d    = idx_q + ADDR_W'(1);
        if (last_elem) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The read is masked while a fill runs or before any fill has completed, so
  // stale or uninitialised words never reach the comparators.
  always_comb begin
    saida_d = (busy_q || !valid_q) ? '0 : mem[address];
  end

  // Memory write port. The memory has no reset because valid masks it.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem[idx_q] <= wr_onehot;
    end
  end

  assign saida = saida_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: doc/seq_gen.md
# seq_gen

Parametrised pattern generator for the Genius game datapath. It replaces the fixed 16-entry colour table with a sequence memory that a free-running LFSR fills on request, so each game gets a fresh sequence. Colours are stored one-hot and read back through an addressed, registered port. The game FSM drives the block, and the LED/button comparators consume its output.

## Interface
- N_COLORS, 4: number of colours and one-hot width; power of two, 2..8.
- ADDR_W, 4: address width; sequence depth DEPTH = 2^ADDR_W.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.
- NO_REPEAT, 1: when 1, no element equals its predecessor.

- clock  in  1  single clock; rising edge only.
- reset  in  1  synchronous, active-high reset.
- new_seq  in  1  request to generate a new sequence; pulse or level.
- address  in  ADDR_W  read index.
- saida  out  N_COLORS  registered one-hot colour at `address`.
- busy  out  1  high while the fill is in progress.
- done  out  1  one-cycle pulse when the fill completes.
- valid  out  1  memory holds a complete sequence.

## Operation
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - It shifts on every clock edge where reset=0, in every state. Player timing supplies the entropy.
  - reset loads SEED.
- Colour index c = lfsr[log2(N_COLORS)-1:0], taken from the value held during the write cycle.
- If NO_REPEAT=1, idx>0 and c equals the previous element's index, the written index is (c+1) mod N_COLORS.
- Element 0 is never altered.
- Memory stores each element as a one-hot value of N_COLORS bits.
- FSM states:
  - IDLE: new_seq=1 moves to FILL, sets idx=0, busy=1, valid=0.
  - FILL: writes mem[idx] and increments idx each cycle. After writing idx=DEPTH-1, returns to IDLE with done=1 and valid=1.
- new_seq is ignored while in FILL. A held new_seq restarts the fill immediately after returning to IDLE.
- Read port: saida <= (busy || !valid) ? 0 : mem[address]. It updates every cycle.
- reset, including mid-fill:
  - state=IDLE, idx=0, lfsr=SEED.
  - saida=0, busy=0, done=0, valid=0.
  - Memory contents are don't-care; valid=0 masks them.

## Timing
- new_seq is sampled at edge T. busy rises after T.
- Element i is written at edge T+1+i, using the lfsr value present during cycle (T+i, T+i+1].
- At edge T+DEPTH:
  - busy falls.
  - done=1 for exactly one cycle.
  - valid=1.
- Read latency: address applied before edge E gives saida valid after E, one cycle.
- First post-fill read is usable at edge T+DEPTH+1.
- Successive fills start no sooner than one IDLE cycle apart, so busy has a minimum 1-cycle low gap.

## Test plan
- **Reset:** assert reset for 2 cycles with new_seq=1.
  - Required: saida=0, busy=0, done=0, valid=0 throughout.
  - Required: no fill starts until reset=0.
- **Fill timing:** deassert reset, then new_seq=1 on the first edge E0 only.
  - Required: busy high for exactly 16 cycles.
  - Required: done high for exactly 1 cycle at E16.
  - Required: valid=1 from E16.
- **Sequence content (defaults, same stimulus):**
  - Read address 0 -> 4'b0001 (lfsr 16'hE270).
  - Read address 1 -> 4'b0010 (lfsr 16'h7138 gives 0001, bumped by NO_REPEAT).
  - All 16 elements match a bit-accurate reference model.
  - No two adjacent elements are equal.
- **Masking during fill:** issue a second new_seq after a completed fill, reading address 5 throughout.
  - Required: saida=0 while busy.
  - Required: the new element 5 appears one cycle after done.
  - Required: new_seq pulses during FILL have no effect.
- **Reset mid-fill:** assert reset at idx=7.
  - Required: busy=0 and valid=0 next cycle.
  - Required: done never pulses.
  - Required: a following new_seq produces the same sequence as the fill-timing scenario, given identical cycle timing.
- **Parameter sweep:** N_COLORS=8, ADDR_W=5, NO_REPEAT=0.
  - Required: 32 elements, each exactly one-hot over 8 bits.
  - Required: busy lasts 32 cycles.
  - Required: contents match the model.
